// File: rtl/apb_decode_mux.sv
// APB decode/response stage: address decode to one-hot slave select, response mux,
// decode-miss error response, per-transfer hung-slave timeout and sticky fault status.
module apb_decode_mux #(
  parameter int unsigned           NUM_SLAVES     = 2,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000,
  parameter int unsigned           SLAVE_SPAN     = 32'h0000_1000,
  parameter int unsigned           TIMEOUT_CYCLES = 16
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  input  logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PRDATA,
  output logic                             PREADY,
  output logic                             PSLVERR,
  output logic [NUM_SLAVES-1:0]            PSEL_slave,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_slave,
  input  logic [NUM_SLAVES-1:0]            PREADY_slave,
  input  logic [NUM_SLAVES-1:0]            PSLVERR_slave,
  input  logic                             fault_clear,
  output logic                             fault_valid,
  output logic [1:0]                       fault_code,
  output logic [ADDR_WIDTH-1:0]            fault_addr,
  output logic [7:0]                       fault_count
);

  localparam int unsigned SHIFT   = $clog2(SLAVE_SPAN);
  localparam int unsigned IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int unsigned TO_LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] CODE_DECODE  = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        sel_idx;
  logic                    sel_hit;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [CNT_W-1:0]        tcnt;
  logic                    to_block;

  logic [ADDR_WIDTH-1:0]   off;
  logic [ADDR_WIDTH-1:0]   idx_full;
  logic                    hit;
  logic [IDX_W-1:0]        idx;

  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    timeout;
  logic                    pready_c;
  logic                    complete;
  logic                    fault_now;
  logic [1:0]              fault_type;

  // Span is a power of two, so the slave index is a plain shift of the offset.
  assign off      = PADDR - BASE_ADDR;
  assign idx_full = off >> SHIFT;
  assign hit      = (PADDR >= BASE_ADDR) && (idx_full < ADDR_WIDTH'(NUM_SLAVES));
  assign idx      = idx_full[IDX_W-1:0];

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_ready = PREADY_slave[i];
        sel_err   = PSLVERR_slave[i];
        sel_rdata = PRDATA_slave[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign timeout = TO_EN && (state == ACCESS) && sel_hit && !sel_ready &&
                   (tcnt == CNT_W'(TO_LAST));

  always_comb begin
    pready_c = 1'b0;
    PSLVERR  = 1'b0;
    PRDATA   = '0;
    if (state == ACCESS) begin
      if (!sel_hit || timeout) begin
        pready_c = 1'b1;
        PSLVERR  = 1'b1;
      end else begin
        pready_c = sel_ready;
        PSLVERR  = sel_err;
        PRDATA   = sel_rdata;
      end
    end
  end

  assign PREADY     = pready_c;
  assign complete   = (state == ACCESS) && PSEL && pready_c;
  assign fault_now  = complete && (!sel_hit || timeout);
  assign fault_type = sel_hit ? CODE_TIMEOUT : CODE_DECODE;

  // Reset gates the select directly so it drops even while the bridge still drives PSEL.
  always_comb begin
    PSEL_slave = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (state == IDLE)
        PSEL_slave[i] = PSEL && hit && (idx == IDX_W'(i));
      else
        PSEL_slave[i] = PSEL && sel_hit && (sel_idx == IDX_W'(i));
    end
    if (to_block || !HRESETn)
      PSEL_slave = '0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      sel_idx  <= '0;
      sel_hit  <= 1'b0;
      sel_addr <= '0;
      tcnt     <= '0;
      to_block <= 1'b0;
    end else begin
      to_block <= complete && timeout;
      unique case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            state    <= SETUP;
            sel_idx  <= idx;
            sel_hit  <= hit;
            sel_addr <= PADDR;
            tcnt     <= '0;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          if (!PSEL || pready_c)
            state <= IDLE;
          else if (TO_EN && sel_hit && !sel_ready)
            tcnt <= tcnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A fault coinciding with a clear restarts the status from that fault.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fault_valid <= 1'b0;
      fault_code  <= '0;
      fault_addr  <= '0;
      fault_count <= '0;
    end else if (fault_now) begin
      if (fault_clear || !fault_valid) begin
        fault_valid <= 1'b1;
        fault_code  <= fault_type;
        fault_addr  <= sel_addr;
      end
      if (fault_clear)
        fault_count <= 8'd1;
      else if (fault_count != 8'hFF)
        fault_count <= fault_count + 8'd1;
    end else if (fault_clear) begin
      fault_valid <= 1'b0;
      fault_code  <= '0;
      fault_addr  <= '0;
      fault_count <= '0;
    end
  end

endmodule

// File: tb/tb_apb_decode_mux.sv
// Self-checking bench for apb_decode_mux: directed test-plan steps followed by
// randomized transfers checked against an address-map / fault-status reference model.
module tb_apb_decode_mux;

  localparam int unsigned   NS   = 2;
  localparam longint unsigned BASE = 64'h8000_0000;
  localparam longint unsigned SPAN = 64'h1000;
  localparam int            TO   = 16;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic            PSEL, PENABLE;
  logic [31:0]     PADDR;
  logic [31:0]     PRDATA;
  logic            PREADY, PSLVERR;
  logic [NS-1:0]   PSEL_slave;
  logic [NS*32-1:0] PRDATA_slave;
  logic [NS-1:0]   PREADY_slave, PSLVERR_slave;
  logic            fault_clear;
  logic            fault_valid;
  logic [1:0]      fault_code;
  logic [31:0]     fault_addr;
  logic [7:0]      fault_count;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_valid;
  logic [1:0]  m_code;
  logic [31:0] m_addr;
  int          m_count;
  bit          m_block;

  apb_decode_mux #(
    .NUM_SLAVES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .BASE_ADDR(32'h8000_0000), .SLAVE_SPAN(32'h0000_1000), .TIMEOUT_CYCLES(16)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PSEL_slave(PSEL_slave),
    .PRDATA_slave(PRDATA_slave), .PREADY_slave(PREADY_slave), .PSLVERR_slave(PSLVERR_slave),
    .fault_clear(fault_clear), .fault_valid(fault_valid), .fault_code(fault_code),
    .fault_addr(fault_addr), .fault_count(fault_count)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_code = 2'b00; m_addr = '0; m_count = 0; m_block = 1'b0;
  endtask

  task automatic model_fault(input bit fault, input logic [1:0] code,
                             input logic [31:0] a, input bit clr);
    if (fault) begin
      if (clr) begin
        m_valid = 1'b1; m_code = code; m_addr = a; m_count = 1;
      end else begin
        if (!m_valid) begin
          m_valid = 1'b1; m_code = code; m_addr = a;
        end
        if (m_count < 255) m_count++;
      end
    end else if (clr) begin
      m_valid = 1'b0; m_code = 2'b00; m_addr = '0; m_count = 0;
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_fault_valid"}, fault_valid, m_valid);
    chk({tag, "_fault_code"},  fault_code,  m_code);
    chk({tag, "_fault_addr"},  fault_addr,  m_addr);
    chk({tag, "_fault_count"}, fault_count, m_count[7:0]);
  endtask

  // Unselected slaves carry random junk so a wrong mux choice shows up.
  task automatic drive_slaves(input int k, input bit hit, input logic rdy,
                              input logic err, input logic [31:0] d);
    PRDATA_slave  = {$urandom, $urandom};
    PREADY_slave  = 2'($urandom);
    PSLVERR_slave = 2'($urandom);
    if (hit) begin
      PRDATA_slave[k*32 +: 32] = d;
      PREADY_slave[k]  = rdy;
      PSLVERR_slave[k] = err;
    end
  endtask

  task automatic idle(input bit clr);
    PSEL = 1'b0; PENABLE = 1'b0; fault_clear = clr;
    drive_slaves(0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    chk("idle_psel_slave", PSEL_slave, '0);
    chk("idle_pready", PREADY, 1'b0);
    chk("idle_prdata", PRDATA, '0);
    model_fault(1'b0, 2'b00, '0, clr);
    m_block = 1'b0;
    tick();
    fault_clear = 1'b0;
    chk("idle_fault_valid", fault_valid, m_valid);
    chk("idle_fault_count", fault_count, m_count[7:0]);
  endtask

  // One APB transfer. w = slave wait states before ready; abort_n / rst_at select an
  // ACCESS cycle in which the master drops PSEL or reset is asserted (0 = never).
  task automatic run_xfer(input logic [31:0] a, input int w, input logic serr,
                          input logic [31:0] sd, input int abort_n, input int rst_at,
                          input bit clr);
    longint unsigned al;
    bit hit, srdy, e_rdy, e_err, is_to, done;
    logic [31:0] e_dat;
    logic [NS-1:0] e_sel;
    int k;
    al  = a;
    hit = (al >= BASE) && ((al - BASE) / SPAN < NS);
    k   = hit ? int'((al - BASE) / SPAN) : 0;
    e_sel = '0;
    if (hit) e_sel[k] = 1'b1;

    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; fault_clear = 1'b0;
    drive_slaves(k, hit, 1'b0, 1'b0, sd);
    #1;
    chk("setup_psel_slave", PSEL_slave, m_block ? '0 : e_sel);
    chk("setup_pready", PREADY, 1'b0);
    m_block = 1'b0;
    tick();

    PENABLE = 1'b1;
    drive_slaves(k, hit, 1'b0, 1'b0, sd);
    #1;
    chk("enable_psel_slave", PSEL_slave, e_sel);
    chk("enable_pready", PREADY, 1'b0);
    chk("enable_prdata", PRDATA, '0);
    tick();

    done = 1'b0;
    for (int n = 1; n <= 40 && !done; n++) begin
      if (n == abort_n) begin
        PSEL = 1'b0; PENABLE = 1'b0;
        drive_slaves(k, hit, 1'b0, 1'b0, sd);
        #1;
        chk("abort_psel_slave", PSEL_slave, '0);
        tick();
        chk("abort_fault_count", fault_count, m_count[7:0]);
        return;
      end
      if (n == rst_at) begin
        HRESETn = 1'b0;
        #1;
        chk("rst_psel_slave", PSEL_slave, '0);
        chk("rst_pready", PREADY, 1'b0);
        chk("rst_pslverr", PSLVERR, 1'b0);
        model_reset();
        chk_status("rst");
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        HRESETn = 1'b1;
        return;
      end
      srdy  = hit && (n > w);
      is_to = 1'b0;
      if (!hit) begin
        e_rdy = 1'b1; e_err = 1'b1; e_dat = '0;
      end else if (srdy) begin
        e_rdy = 1'b1; e_err = serr; e_dat = sd;
      end else if (n == TO) begin
        e_rdy = 1'b1; e_err = 1'b1; e_dat = '0; is_to = 1'b1;
      end else begin
        e_rdy = 1'b0; e_err = 1'b0; e_dat = sd;
      end
      fault_clear = clr && e_rdy;
      drive_slaves(k, hit, srdy, srdy && serr, sd);
      #1;
      chk("access_psel_slave", PSEL_slave, e_sel);
      chk("access_pready", PREADY, e_rdy);
      chk("access_pslverr", PSLVERR, e_err);
      chk("access_prdata", PRDATA, e_dat);
      if (e_rdy) begin
        model_fault(!hit || is_to, hit ? 2'b10 : 2'b01, a, clr);
        m_block = is_to;
        done = 1'b1;
      end
      tick();
      fault_clear = 1'b0;
    end
    if (!done) chk("xfer_completion_bound", 1'b0, 1'b1);
    chk_status("done");
  endtask

  logic [31:0] ra;
  int          rw, rsel, rab;

  initial begin
    PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; fault_clear = 1'b0;
    PRDATA_slave = '0; PREADY_slave = '0; PSLVERR_slave = '0;
    model_reset();
    HRESETn = 1'b1;
    #2 HRESETn = 1'b0;
    #1;
    chk("reset_psel_slave", PSEL_slave, '0);
    chk("reset_pready", PREADY, 1'b0);
    chk("reset_pslverr", PSLVERR, 1'b0);
    chk("reset_prdata", PRDATA, '0);
    chk_status("reset");
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Plain read from slave 1.
    run_xfer(32'h8000_1004, 0, 1'b0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    chk("tp1_fault_valid", fault_valid, 1'b0);
    idle(1'b0);
    // Unmapped address just past the last slave.
    run_xfer(32'h8000_2000, 0, 1'b0, $urandom, 0, 0, 1'b0);
    chk("tp2_fault_code", fault_code, 2'b01);
    chk("tp2_fault_addr", fault_addr, 32'h8000_2000);
    chk("tp2_fault_count", fault_count, 8'd1);
    idle(1'b1);
    // Hung slave 0, then a back-to-back transfer whose setup cycle sees the blocked select.
    run_xfer(32'h8000_0010, 1000, 1'b0, $urandom, 0, 0, 1'b0);
    chk("tp3_fault_code", fault_code, 2'b10);
    run_xfer(32'h8000_0020, 3, 1'b1, $urandom, 0, 0, 1'b0);
    chk("tp4_fault_count", fault_count, 8'd1);
    idle(1'b1);
    // Decode fault, timeout fault, then a timeout coinciding with a clear.
    run_xfer(32'h7FFF_FFFF, 0, 1'b0, $urandom, 0, 0, 1'b0);
    run_xfer(32'h8000_1FFC, 1000, 1'b0, $urandom, 0, 0, 1'b0);
    chk("tp5_code_sticky", fault_code, 2'b01);
    chk("tp5_count_two", fault_count, 8'd2);
    run_xfer(32'h8000_1000, 1000, 1'b0, $urandom, 0, 0, 1'b1);
    chk("tp5_clr_valid", fault_valid, 1'b1);
    chk("tp5_clr_code", fault_code, 2'b10);
    chk("tp5_clr_count", fault_count, 8'd1);
    for (int i = 0; i < 300; i++)
      run_xfer(32'h8000_2000 + 32'(i), 0, 1'b0, $urandom, 0, 0, 1'b0);
    chk("tp5_saturate", fault_count, 8'd255);
    // Reset during ACCESS with slave 1 selected, then a normal transfer.
    run_xfer(32'h8000_1000, 1000, 1'b0, $urandom, 0, 3, 1'b0);
    run_xfer(32'h8000_1008, 1, 1'b0, 32'h1234_5678, 0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      rsel = $urandom_range(0, 11);
      if (rsel < 4)       ra = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      else if (rsel < 8)  ra = 32'h8000_1000 | ($urandom & 32'h0000_0FFF);
      else if (rsel == 8) ra = 32'h8000_2000 + ($urandom & 32'h0FFF_FFFF);
      else if (rsel == 9) ra = $urandom & 32'h7FFF_FFFF;
      else if (rsel == 10) ra = 32'hFFFF_FFFF;
      else                ra = 32'h8000_1FFF;
      rw  = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 3));
      rab = 0;
      if (rsel < 8 && rw >= 1 && $urandom_range(0, 9) == 0)
        rab = int'($urandom_range(1, (rw > TO) ? TO : rw));
      run_xfer(ra, rw, 1'($urandom), $urandom, rab, 0, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 5) == 0);
    end
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
